// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU-control codes, funct constants, forward selects and mul/div encodings
// for the ex_pipe_stage_md execute stage.
package ex_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_MFHI = 4'd8;
    localparam logic [3:0] ALU_MFLO = 4'd9;
    localparam logic [3:0] ALU_ZERO = 4'd10;

    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // 00 and 11 both select the register operand
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

    // mult/multu/div/divu occupy 0x18..0x1B
    function automatic logic is_md_funct(input logic [5:0] f);
        return (f & 6'h3C) == F_MULT;
    endfunction
endpackage

// File: rtl/ex_pipe_stage_md_if.sv
// ex_pipe_stage_md_if: ID/EX operands, forwarding inputs and EX results of the execute stage.
interface ex_pipe_stage_md_if #(parameter int DATA_WIDTH = 32);
    logic [31:0]           id_ex_instr;
    logic                  id_ex_valid;
    logic [DATA_WIDTH-1:0] id_ex_reg1;
    logic [DATA_WIDTH-1:0] id_ex_reg2;
    logic [DATA_WIDTH-1:0] id_ex_imm_value;
    logic [DATA_WIDTH-1:0] ex_mem_alu_result;
    logic [DATA_WIDTH-1:0] mem_wb_write_back_result;
    logic                  id_ex_alu_src;
    logic [1:0]            id_ex_alu_op;
    logic [1:0]            Forward_A;
    logic [1:0]            Forward_B;
    logic [DATA_WIDTH-1:0] alu_in2_out;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  ex_stall;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output id_ex_instr, id_ex_valid, id_ex_reg1, id_ex_reg2, id_ex_imm_value,
               ex_mem_alu_result, mem_wb_write_back_result, id_ex_alu_src, id_ex_alu_op,
               Forward_A, Forward_B,
        input  alu_in2_out, alu_result, ex_stall, hi_out, lo_out
    );

    modport slave (
        input  id_ex_instr, id_ex_valid, id_ex_reg1, id_ex_reg2, id_ex_imm_value,
               ex_mem_alu_result, mem_wb_write_back_result, id_ex_alu_src, id_ex_alu_op,
               Forward_A, Forward_B,
        output alu_in2_out, alu_result, ex_stall, hi_out, lo_out
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 multiply/divide with architectural HI/LO registers.
// EX_MD_EARLY_EXIT_EN: multiply finishes once the remaining multiplier bits are all zero.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  md_op_e                op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;

    md_state_e state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0] acc, mcand, acc_step, prod;
    logic [W-1:0] bq, abs_a, abs_b, quo, rem;
    logic [W:0] sh, diff;
    logic is_div, neg_q, neg_r, s_op, last, zero_exit, qb;

    assign s_op  = ~op[0];
    assign abs_a = (s_op && a[W-1]) ? -a : a;
    assign abs_b = (s_op && b[W-1]) ? -b : b;

    // divide: acc = {remainder, dividend shifting out / quotient shifting in}
    // multiply: acc = running product, mcand shifts left, bq (multiplier) shifts right
    assign sh       = {acc[2*W-1:W], acc[W-1]};
    assign diff     = sh - {1'b0, bq};
    assign qb       = ~diff[W];
    assign acc_step = is_div ? {qb ? diff[W-1:0] : sh[W-1:0], acc[W-2:0], qb}
                             : acc + (bq[0] ? mcand : '0);
    assign quo      = acc_step[W-1:0];
    assign rem      = acc_step[2*W-1:W];
    assign prod     = neg_q ? -acc_step : acc_step;

`ifdef EX_MD_EARLY_EXIT_EN
    assign zero_exit = ~op[1] && abs_b == '0;
    assign last      = cnt == CNT_WIDTH'(W - 1) || (!is_div && bq[W-1:1] == '0);
`else
    assign zero_exit = 1'b0;
    assign last      = cnt == CNT_WIDTH'(W - 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= MD_IDLE;
        else
            state <= state_nxt;
    end

    // DONE never looks at start: the finished instruction is still sitting in EX
    always_comb begin
        busy      = !reset && (state == MD_BUSY || (state == MD_IDLE && start));
        state_nxt = state == MD_IDLE ? (start ? (zero_exit ? MD_DONE : MD_BUSY) : MD_IDLE) :
                    state == MD_BUSY ? (last ? MD_DONE : MD_BUSY) : MD_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            bq     <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == MD_IDLE && start) begin
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= s_op && (a[W-1] ^ b[W-1]) && b != '0;
            neg_r  <= s_op && a[W-1];
            acc    <= op[1] ? {{W{1'b0}}, abs_a} : '0;
            mcand  <= {{W{1'b0}}, abs_a};
            bq     <= abs_b;
            if (zero_exit) begin
                hi <= '0;
                lo <= '0;
            end
        end else if (state == MD_BUSY) begin
            cnt   <= cnt + CNT_WIDTH'(1);
            acc   <= acc_step;
            mcand <= mcand << 1;
            bq    <= is_div ? bq : bq >> 1;
            if (last)
                {hi, lo} <= is_div ? {neg_r ? -rem : rem, neg_q ? -quo : quo} : prod;
        end
    end
endmodule

// File: rtl/ex_pipe_stage_md.sv
// ex_pipe_stage_md: MIPS execute stage with forwarding, ALU and an iterative mul/div unit.
// EX_MD_EARLY_EXIT_EN (in ex_muldiv_unit) shortens multiplies with small multipliers.
module ex_pipe_stage_md
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input logic              clk,
    input logic              reset,
    ex_pipe_stage_md_if.slave bus
);
    logic [DATA_WIDTH-1:0] op_a, op_b_fwd, op_b, alu_out, hi, lo;
    logic [5:0] funct;
    logic [3:0] alu_ctrl;
    logic md_start, md_busy, unused_instr;

    function automatic logic [DATA_WIDTH-1:0] fwd(input logic [1:0] sel,
                                                  input logic [DATA_WIDTH-1:0] r, m, w);
        return sel == FWD_MEM ? m : sel == FWD_WB ? w : r;
    endfunction

    assign funct        = bus.id_ex_instr[5:0];
    assign unused_instr = ^bus.id_ex_instr[31:6];
    assign op_a     = fwd(bus.Forward_A, bus.id_ex_reg1, bus.ex_mem_alu_result, bus.mem_wb_write_back_result);
    assign op_b_fwd = fwd(bus.Forward_B, bus.id_ex_reg2, bus.ex_mem_alu_result, bus.mem_wb_write_back_result);
    assign op_b     = bus.id_ex_alu_src ? bus.id_ex_imm_value : op_b_fwd;
    assign md_start = bus.id_ex_valid && bus.id_ex_alu_op == ALUOP_FUNCT && is_md_funct(funct);

    always_comb begin
        alu_ctrl = ALU_ZERO;
        case (bus.id_ex_alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_OR:  alu_ctrl = ALU_OR;
            default:
                case (funct)
                    F_ADD, F_ADDU: alu_ctrl = ALU_ADD;
                    F_SUB, F_SUBU: alu_ctrl = ALU_SUB;
                    F_AND:  alu_ctrl = ALU_AND;
                    F_OR:   alu_ctrl = ALU_OR;
                    F_XOR:  alu_ctrl = ALU_XOR;
                    F_NOR:  alu_ctrl = ALU_NOR;
                    F_SLT:  alu_ctrl = ALU_SLT;
                    F_SLTU: alu_ctrl = ALU_SLTU;
                    F_MFHI: alu_ctrl = ALU_MFHI;
                    F_MFLO: alu_ctrl = ALU_MFLO;
                    default: alu_ctrl = ALU_ZERO;
                endcase
        endcase
    end

    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_out = op_a + op_b;
            ALU_SUB:  alu_out = op_a - op_b;
            ALU_AND:  alu_out = op_a & op_b;
            ALU_OR:   alu_out = op_a | op_b;
            ALU_XOR:  alu_out = op_a ^ op_b;
            ALU_NOR:  alu_out = ~(op_a | op_b);
            ALU_SLT:  alu_out = DATA_WIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_out = DATA_WIDTH'(op_a < op_b);
            ALU_MFHI: alu_out = hi;
            ALU_MFLO: alu_out = lo;
            default:  alu_out = '0;
        endcase
    end

    // mul/div takes the forwarded register operands, never the immediate
    ex_muldiv_unit #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_md (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .op    (md_op_e'(funct[1:0])),
        .a     (op_a),
        .b     (op_b_fwd),
        .busy  (md_busy),
        .hi    (hi),
        .lo    (lo)
    );

    assign bus.alu_in2_out = op_b_fwd;
    assign bus.alu_result  = alu_out;
    assign bus.ex_stall    = md_busy;
    assign bus.hi_out      = hi;
    assign bus.lo_out      = lo;
endmodule

// File: tb/tb_ex_pipe_stage_md.sv
// tb_ex_pipe_stage_md: directed vector bench for ex_pipe_stage_md (32- and 16-bit instances).
module tb_ex_pipe_stage_md;
    logic clk = 1'b0;
    logic reset;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_pipe_stage_md_if #(.DATA_WIDTH(32)) b32();
    ex_pipe_stage_md_if #(.DATA_WIDTH(16)) b16();

    ex_pipe_stage_md #(.DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(b32.slave));
    ex_pipe_stage_md #(.DATA_WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));

    typedef struct {
        logic [5:0]  funct;
        logic [1:0]  aop;
        logic        src;
        logic [1:0]  fa, fb;
        logic [31:0] r1, r2, imm, exm, wb, res, in2;
    } alu_vec_t;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a, b, hi, lo;
        int          st_full, st_early;
    } md_vec_t;

    alu_vec_t av[15];
    md_vec_t  mv[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] funct, input logic [1:0] aop, input logic src,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic [31:0] exm, input logic [31:0] wb, input logic valid);
        b32.id_ex_instr = {26'h0, funct};
        b32.id_ex_alu_op = aop;
        b32.id_ex_alu_src = src;
        b32.Forward_A = fa;
        b32.Forward_B = fb;
        b32.id_ex_reg1 = r1;
        b32.id_ex_reg2 = r2;
        b32.id_ex_imm_value = imm;
        b32.ex_mem_alu_result = exm;
        b32.mem_wb_write_back_result = wb;
        b32.id_ex_valid = valid;
    endtask

    task automatic run_md(input int i);
        int n = 0;
        int exp_st;
`ifdef EX_MD_EARLY_EXIT_EN
        exp_st = mv[i].st_early;
`else
        exp_st = mv[i].st_full;
`endif
        @(negedge clk);
        drive(mv[i].funct, 2'b10, 1'b0, 2'b00, 2'b00, mv[i].a, mv[i].b, 32'h0, 32'h0, 32'h0, 1'b1);
        #1;
        while (b32.ex_stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk($sformatf("md%0d_stall", i), 64'(n), 64'(exp_st));
        chk($sformatf("md%0d_hi", i), 64'(b32.hi_out), 64'(mv[i].hi));
        chk($sformatf("md%0d_lo", i), 64'(b32.lo_out), 64'(mv[i].lo));
        drive(6'h12, 2'b10, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        #1;
        chk($sformatf("md%0d_mflo", i), 64'(b32.alu_result), 64'(mv[i].lo));
        @(negedge clk);
        drive(6'h10, 2'b10, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        #1;
        chk($sformatf("md%0d_mfhi", i), 64'(b32.alu_result), 64'(mv[i].hi));
        b32.id_ex_valid = 1'b0;
    endtask

    task automatic run16(input logic [5:0] funct, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ehi, input logic [15:0] elo, input string name);
        int n = 0;
        @(negedge clk);
        b16.id_ex_instr = {26'h0, funct};
        b16.id_ex_alu_op = 2'b10;
        b16.id_ex_reg1 = a;
        b16.id_ex_reg2 = b;
        b16.id_ex_valid = 1'b1;
        #1;
        while (b16.ex_stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        b16.id_ex_valid = 1'b0;
        chk({name, "_stall"}, 64'(n), 64'd17);
        chk({name, "_hi"}, 64'(b16.hi_out), 64'(ehi));
        chk({name, "_lo"}, 64'(b16.lo_out), 64'(elo));
    endtask

    initial begin
        av[0]  = '{6'h22, 2'b10, 1'b0, 2'b10, 2'b00, 32'd0, 32'd5, 32'd0, 32'd7, 32'd0, 32'd2, 32'd5};
        av[1]  = '{6'h25, 2'b10, 1'b0, 2'b00, 2'b01, 32'd6, 32'd0, 32'd0, 32'd0, 32'd9, 32'hF, 32'd9};
        av[2]  = '{6'h00, 2'b00, 1'b1, 2'b00, 2'b00, 32'd1, 32'h55, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'h55};
        av[3]  = '{6'h00, 2'b01, 1'b0, 2'b00, 2'b00, 32'd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFE, 32'd5};
        av[4]  = '{6'h00, 2'b11, 1'b0, 2'b00, 2'b00, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'd0, 32'hFF, 32'h0F};
        av[5]  = '{6'h24, 2'b10, 1'b0, 2'b00, 2'b00, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 32'd0, 32'd0, 32'h0F000F00, 32'h0FF00FF0};
        av[6]  = '{6'h26, 2'b10, 1'b0, 2'b00, 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'd0, 32'd0, 32'd0, 32'hF0F00F0F, 32'h0F0F0F0F};
        av[7]  = '{6'h27, 2'b10, 1'b0, 2'b00, 2'b00, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 32'd0, 32'd0, 32'h00000F0F, 32'h0F0F0000};
        av[8]  = '{6'h2A, 2'b10, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
        av[9]  = '{6'h2B, 2'b10, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
        av[10] = '{6'h21, 2'b10, 1'b0, 2'b11, 2'b11, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h100, 32'h200, 32'h80000000, 32'd1};
        av[11] = '{6'h3F, 2'b10, 1'b0, 2'b00, 2'b00, 32'd5, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3};
        av[12] = '{6'h23, 2'b10, 1'b0, 2'b00, 2'b10, 32'h20, 32'h99, 32'd0, 32'h10, 32'd0, 32'h10, 32'h10};
        av[13] = '{6'h10, 2'b10, 1'b0, 2'b00, 2'b00, 32'd5, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3};
        av[14] = '{6'h20, 2'b10, 1'b1, 2'b00, 2'b01, 32'd5, 32'd3, 32'h10, 32'd0, 32'h77, 32'h15, 32'h77};

        mv[0] = '{6'h18, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 33, 4};
        mv[1] = '{6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 33, 33};
        mv[2] = '{6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
        mv[3] = '{6'h1A, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33, 33};
        mv[4] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, 33};
        mv[5] = '{6'h1A, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 33};
        mv[6] = '{6'h19, 32'h1234, 32'd3, 32'd0, 32'h369C, 33, 3};
        mv[7] = '{6'h19, 32'h1234, 32'd0, 32'd0, 32'd0, 33, 1};
        mv[8] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 33, 33};
        mv[9] = '{6'h18, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'h80000000, 33, 33};

        reset = 1'b1;
        drive(6'h18, 2'b10, 1'b0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 1'b1);
        b16.id_ex_instr = '0;
        b16.id_ex_valid = 1'b0;
        b16.id_ex_reg1 = '0;
        b16.id_ex_reg2 = '0;
        b16.id_ex_imm_value = '0;
        b16.ex_mem_alu_result = '0;
        b16.mem_wb_write_back_result = '0;
        b16.id_ex_alu_src = 1'b0;
        b16.id_ex_alu_op = 2'b00;
        b16.Forward_A = 2'b00;
        b16.Forward_B = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 64'(b32.ex_stall), 64'd0);
        chk("rst_hi", 64'(b32.hi_out), 64'd0);
        chk("rst_lo", 64'(b32.lo_out), 64'd0);
        b32.id_ex_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(av[i].funct, av[i].aop, av[i].src, av[i].fa, av[i].fb, av[i].r1, av[i].r2,
                  av[i].imm, av[i].exm, av[i].wb, 1'b1);
            #1;
            chk($sformatf("alu%0d_res", i), 64'(b32.alu_result), 64'(av[i].res));
            chk($sformatf("alu%0d_in2", i), 64'(b32.alu_in2_out), 64'(av[i].in2));
            chk($sformatf("alu%0d_stall", i), 64'(b32.ex_stall), 64'd0);
        end

        for (int i = 0; i < 10; i++)
            run_md(i);

        @(negedge clk);
        drive(6'h18, 2'b10, 1'b0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("bubble_stall0", 64'(b32.ex_stall), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("bubble_stall3", 64'(b32.ex_stall), 64'd0);
        chk("bubble_hi", 64'(b32.hi_out), 64'd0);
        chk("bubble_lo", 64'(b32.lo_out), 64'h80000000);

        @(negedge clk);
        drive(6'h18, 2'b10, 1'b0, 2'b00, 2'b00, 32'd7, 32'd9, 32'd0, 32'd0, 32'd0, 1'b1);
        repeat (10) @(negedge clk);
        b32.Forward_A = 2'b10;
        b32.ex_mem_alu_result = 32'd1000;
        #1;
        chk("midrst_busy", 64'(b32.ex_stall), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_stall", 64'(b32.ex_stall), 64'd0);
        chk("midrst_hi", 64'(b32.hi_out), 64'd0);
        chk("midrst_lo", 64'(b32.lo_out), 64'd0);
        b32.id_ex_valid = 1'b0;
        b32.Forward_A = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        run_md(0);

        run16(6'h19, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, "m16");
        run16(6'h1B, 16'd1000, 16'd7, 16'd6, 16'd142, "d16");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_pipe_stage_md.md
Name: ex_pipe_stage_md

Overview:
Parametrised next-generation MIPS execute stage.
- Same forwarding muxes, ALU-source mux, ALU-control decode and ALU as the current EX stage.
- Adds an iterative multiply/divide unit with architectural HI/LO registers and MFHI/MFLO support.
- Adds an ex_stall output that holds the ID/EX register and earlier stages while a MULT/DIV runs.
- Sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
DATA_WIDTH, 32, datapath width of operands, ALU, HI and LO.
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration-counter width.

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
id_ex_instr  in  32  instruction in EX; funct = [5:0]
id_ex_valid  in  1  0 = bubble; a bubble never starts mul/div
id_ex_reg1, id_ex_reg2  in  DATA_WIDTH  register-file operands
id_ex_imm_value  in  DATA_WIDTH  sign-extended immediate
ex_mem_alu_result  in  DATA_WIDTH  EX/MEM forward source
mem_wb_write_back_result  in  DATA_WIDTH  MEM/WB forward source
id_ex_alu_src  in  1  1 = immediate to ALU B
id_ex_alu_op  in  2  00 add, 01 sub, 10 R-type funct decode, 11 or
Forward_A, Forward_B  in  2  forwarding selects
alu_in2_out  out  DATA_WIDTH  forwarded B operand, used as store data
alu_result  out  DATA_WIDTH  ALU or HI/LO result
ex_stall  out  1  hold ID/EX and earlier stages
hi_out, lo_out  out  DATA_WIDTH  architectural HI and LO

Behaviour:
Forwarding select encoding:
- 00 = register operand.
- 01 = mem_wb_write_back_result.
- 10 = ex_mem_alu_result.
- 11 = register operand (defined, not X).

Combinational ALU path:
- alu_in2_out = Forward_B mux output.
- B operand = imm when id_ex_alu_src = 1, else the forwarded value.
- R-type funct decode: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt (signed), 0x2B sltu.
- 0x10 gives alu_result = hi_out; 0x12 gives alu_result = lo_out.
- Any other funct gives alu_result = 0.
- Results wrap modulo 2^DATA_WIDTH; no overflow flag.

Mul/div operations:
- Funct codes: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
- An instruction is a mul/div op only when id_ex_alu_op = 10 and id_ex_valid = 1.
- During a mul/div op, alu_result = 0.

Mul/div FSM, states IDLE, BUSY, DONE:
- IDLE:
  - On a mul/div op, ex_stall = 1 combinationally in that same cycle.
  - Latch |A| and |B| (signed ops) or raw A and B (unsigned ops).
  - Latch the result sign; cnt = 0; next state BUSY.
- BUSY:
  - ex_stall = 1.
  - One radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
  - After step cnt = DATA_WIDTH-1: write HI/LO (sign-corrected), then go to DONE.
- DONE:
  - ex_stall = 0, so the same instruction leaves EX.
  - Never restarts an operation; next state IDLE.
- Stall length: exactly DATA_WIDTH+1 cycles per mul/div.
- An MFHI/MFLO directly after a mul/div sees the new HI/LO.

Results:
- Multiply: {HI, LO} = full 2*DATA_WIDTH product.
- Divide: LO = quotient, HI = remainder; remainder takes the sign of the dividend.
- Divide by zero: HI = dividend, LO = all ones; no exception.
- Signed MIN / -1: LO = MIN, HI = 0.

Reset (asynchronous, any time, including mid-operation):
- State returns to IDLE; hi_out = lo_out = 0; ex_stall = 0; counter and partial results are cleared.
- HI/LO are never partially written.

Forwarding-select changes during BUSY are ignored, because operands were latched at start.

Optional Feature:
EX_MD_EARLY_EXIT_EN:
- Defined: for mult/multu, go to DONE as soon as the remaining multiplier bits are all zero. The stall is then (index of the highest set bit of |B|) + 2 cycles. A zero multiplier stalls 1 cycle: IDLE, then DONE. Divide is unchanged.
- Undefined: fixed DATA_WIDTH+1 stall for every operation.

Decomposition:
Package ex_pkg:
- ALU control code localparams.
- Funct code constants.
- FSM state encoding (IDLE, BUSY, DONE).
- Forward-select encodings.

Sub-module ex_muldiv_unit:
- Contains the FSM, counter, partial product/remainder and HI/LO registers.
- Exposes start, op, a, b, busy/stall, hi, lo.
- The top level contains the muxes, ALU control and ALU.

Test Plan:
1. Forward_A=10, ex_mem_alu_result=7, reg2=5, funct 0x22 -> alu_result=2; Forward_B=01, wb=9, funct 0x25, reg1=6 -> alu_result=0xF, alu_in2_out=9.
2. mult A=-3, B=5 -> ex_stall high 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1; next mflo returns 0xFFFFFFF1.
3. divu 100/7 -> LO=14, HI=2; div -7/2 -> LO=-3, HI=-1; div 5/0 -> HI=5, LO=0xFFFFFFFF.
4. id_ex_valid=0 with mult funct -> ex_stall stays 0, HI/LO unchanged; reset pulsed at BUSY cycle 10 -> IDLE, ex_stall=0, HI=LO=0 immediately.
5. With EX_MD_EARLY_EXIT_EN: multu A=0x1234, B=3 -> stall 3 cycles, LO=0x369C; B=0 -> stall 1 cycle, HI=LO=0.
6. DATA_WIDTH=16: multu 0xFFFF*0xFFFF -> HI=0xFFFE, LO=0x0001, stall 17 cycles.
